// File: rtl/traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_gen : header+counter flit source driving one NoC router port       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module traffic_gen #(
  parameter int          WIDTH        = 32,
  parameter int          N            = 16,
  parameter int          N_ADDR_WIDTH = $clog2(N),
  parameter logic [7:0]  ID           = 8'd0,
  parameter int          NODE         = 0,
  parameter int          DEST_MODE    = 0,
  parameter int          DST          = 15,
  parameter int          GAP_CYCLES   = 0,
  parameter int          NUM_TESTS    = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  output logic [WIDTH-1:0]                    data_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                done,
  output logic [WIDTH-2*N_ADDR_WIDTH-8-1:0]   sent_count
);

  localparam int c_naw = N_ADDR_WIDTH;
  localparam int c_dw  = WIDTH - 2*N_ADDR_WIDTH - 8;

  localparam logic [c_naw-1:0] c_node    = c_naw'(NODE);
  localparam logic [c_naw-1:0] c_node_p1 = c_naw'(NODE + 1);
  localparam logic [c_naw-1:0] c_dst     = c_naw'(DST);
  localparam logic [c_dw-1:0]  c_num     = c_dw'(NUM_TESTS);
  localparam logic [31:0]      c_gap     = 32'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_data;
  logic [c_dw-1:0]   r_sent;
  logic [c_naw-1:0]  r_rr_ptr;
  logic [15:0]       r_lfsr;
  logic [31:0]       r_gap;

  logic              w_accept;
  logic              w_load;
  logic              w_load_next;
  logic [c_dw-1:0]   w_cnt_inc;
  logic [c_dw-1:0]   w_cnt_inc2;
  logic [c_naw-1:0]  w_rr_inc;
  logic [c_naw-1:0]  w_rr_next;
  logic [15:0]       w_lfsr_next;
  logic [c_naw-1:0]  w_dst_cur;
  logic [c_naw-1:0]  w_dst_nxt;
  logic [WIDTH-1:0]  w_flit;

  function automatic logic [c_naw-1:0] pick_dst(input logic [c_naw-1:0] rr,
                                                 input logic [15:0]      lf);
    logic [c_naw-1:0] r;
    if (DEST_MODE == 1)
      r = rr;
    else if (DEST_MODE == 2)
      r = (lf[c_naw-1:0] == c_node) ? c_node_p1 : lf[c_naw-1:0];
    else
      r = c_dst;
    return r;
  endfunction

  assign w_accept    = (r_state == S_SEND) && ready_in;
  assign w_cnt_inc   = r_sent + 1'b1;
  assign w_cnt_inc2  = r_sent + 2'd2;
  assign w_rr_inc    = r_rr_ptr + 1'b1;
  assign w_rr_next   = (w_rr_inc == c_node) ? w_rr_inc + 1'b1 : w_rr_inc;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_dst_cur   = pick_dst(r_rr_ptr, r_lfsr);
  assign w_dst_nxt   = pick_dst(w_rr_next, w_lfsr_next);

  // A back-to-back reload sees the pointers and count as they will be after this accept.
  assign w_flit = w_load_next ? {c_node, w_dst_nxt, ID, w_cnt_inc2}
                              : {c_node, w_dst_cur, ID, w_cnt_inc};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (ready_in) begin
          if (w_cnt_inc == c_num) begin
            w_state_nxt = S_DONE;
          end else if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
          end else if (enable) begin
            w_load      = 1'b1;
            w_load_next = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // Last gap cycle applies the idle-start rule directly so exactly GAP_CYCLES bubbles appear.
        if (r_gap <= 32'd1) begin
          if (enable) begin
            w_state_nxt = S_SEND;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_sent   <= '0;
      r_rr_ptr <= c_node_p1;
      r_lfsr   <= LFSR_SEED;
      r_gap    <= '0;
    end else begin
      if (w_accept) begin
        r_sent   <= w_cnt_inc;
        r_rr_ptr <= w_rr_next;
        r_lfsr   <= w_lfsr_next;
      end
      if (w_load)
        r_data <= w_flit;
      if (w_accept)
        r_gap <= c_gap;
      else if (r_state == S_GAP)
        r_gap <= r_gap - 32'd1;
    end
  end

  assign data_out   = r_data;
  assign valid_out  = (r_state == S_SEND);
  assign done       = (r_state == S_DONE);
  assign sent_count = r_sent;

endmodule
`default_nettype wire
